fmap_buffer: RTL and testbench
==============================

// Module: fmap_buffer
// PURPOSE
//   Responder end of the conv feature-map BRAM interface; in-place elementwise passes (e.g. ReLU) read on Port A, write back on Port B.
//   Simple dual-port store, DEPTH=CHANNELS*IMG_SIZE*IMG_SIZE words, 1-cycle synchronous read.
//   Adds a same-address write->read bypass, a zero-fill (clear) engine and out-of-range address detection.
//   Sits between the conv engine/activation passes and the pooling stage.
// PARAMETERS
//   DATA_WIDTH  16  word width, signed two's complement
//   CHANNELS    8   feature-map channels
//   IMG_SIZE    28  rows = cols per channel
//   (derived) DEPTH = CHANNELS*IMG_SIZE*IMG_SIZE = 6272; AW = $clog2(DEPTH) = 13
// PORTS
//   clk          in   1           system clock, all logic on posedge
//   reset        in   1           asynchronous, active-high
//   conv_r_addr  in   AW          Port A read address
//   conv_r_en    in   1           Port A read enable
//   conv_r_q     out  DATA_WIDTH  Port A read data (signed), registered
//   conv_w_addr  in   AW          Port B write address
//   conv_w_en    in   1           Port B enable
//   conv_w_we    in   1           Port B write strobe; write only when en&&we
//   conv_w_d     in   DATA_WIDTH  Port B write data (signed)
//   clear_start  in   1           1-cycle pulse: zero-fill whole buffer
//   clear_busy   out  1           high while zero-fill runs
//   clear_done   out  1           1-cycle pulse after last zero written
//   oor_err      out  1           sticky: any enabled access with addr >= DEPTH
// BEHAVIOUR
//   Reset (async assert, sync release): conv_r_q=0, clear_busy=0, clear_done=0, oor_err=0, FSM=IDLE, clear ptr=0. Memory array NOT reset.
//   Read: conv_r_en sampled high at edge N -> conv_r_q = mem[conv_r_addr] from edge N; conv_r_q holds when conv_r_en=0.
//   Write: conv_w_en&&conv_w_we at edge N -> mem[conv_w_addr]=conv_w_d at edge N.
//   Collision (read and write same addr, same edge): write-first; conv_r_q = conv_w_d (bypass mux).
//   Out-of-range (addr >= DEPTH, possible as DEPTH not power of 2): write dropped; read returns 0; oor_err set, held until reset or clear_start.
//   Clear FSM: IDLE -> CLEAR on clear_start; CLEAR writes 0 to ptr, ptr++ per cycle, exactly DEPTH cycles; at ptr==DEPTH-1 -> DONE; DONE: clear_done=1 one cycle -> IDLE.
//   clear_busy=1 in CLEAR and DONE. clear_start accepted only in IDLE; ignored (no restart) while busy.
//   clear_start in IDLE also clears oor_err at the same edge.
//   While clear_busy: client writes ignored; client reads update conv_r_q to 0; oor_err not updated.
//   Reset mid-clear: FSM->IDLE immediately, no clear_done; contents partially zeroed, undefined beyond ptr.
//   No back-pressure: client may issue one read and one write every cycle.
// STRUCTURE
//   cnn_pkg: fmap_depth(ch,img) and fmap_aw(ch,img) functions, word_t typedef (signed DATA_WIDTH), clr_st_t enum {IDLE,CLEAR,DONE}.
//   Sub-module fmap_ram_core: plain simple-dual-port array (one write port, one registered read port), no reset, infers BRAM.
//   Top holds port muxing (client vs clear engine), range checks, bypass mux, clear FSM, oor_err flag.
// TESTING
//   1 Write 0x1234 @5, then read @5 next cycle -> conv_r_q=0x1234 one cycle after conv_r_en.
//   2 Same edge: write 0x7FFF @100 and read @100 -> conv_r_q=0x7FFF (write-first); old value never seen.
//   3 Fill all DEPTH words with addr^0x5A5, clear_start -> clear_busy high 6273 cycles incl. DONE, clear_done pulse once; every read returns 0.
//   4 Read @6272 and write @8000 -> oor_err=1, conv_r_q=0, mem[6272 mod 8192 alias] unchanged; clear_start -> oor_err=0.
//   5 clear_start, pulse again at cycle 10, assert reset at cycle 20 -> no restart; outputs 0 during reset; no clear_done; addrs 0..18 read 0.
//   6 Back-to-back read-modify-write sweep (read A, write max(v,0) to A two cycles later) over all DEPTH -> negatives become 0, positives unchanged.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the conv feature-map storage blocks.
package cnn_pkg;

  localparam int WORD_W = 16;

  typedef logic signed [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_st_t;

  // Where the registered read data comes from on the next cycle.
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_BYP} rd_src_t;

  function automatic int fmap_depth(input int ch, input int img);
    return ch * img * img;
  endfunction

  function automatic int fmap_aw(input int ch, input int img);
    return $clog2(fmap_depth(ch, img));
  endfunction

endpackage

// File: rtl/fmap_ram_core.sv
// Plain simple-dual-port word store: one write port, one registered read port, no reset.
module fmap_ram_core #(
  parameter int W     = 16,
  parameter int DEPTH = 6272,
  parameter int AW    = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fmap_buffer.sv
// Feature-map buffer: client read/write ports over a BRAM core, write-first bypass,
// zero-fill engine and sticky out-of-range flag.
module fmap_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IMG_SIZE   = 28,
  localparam int DEPTH     = fmap_depth(CHANNELS, IMG_SIZE),
  localparam int AW        = fmap_aw(CHANNELS, IMG_SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [AW-1:0]                conv_r_addr,
  input  logic                         conv_r_en,
  output logic signed [DATA_WIDTH-1:0] conv_r_q,
  input  logic [AW-1:0]                conv_w_addr,
  input  logic                         conv_w_en,
  input  logic                         conv_w_we,
  input  logic signed [DATA_WIDTH-1:0] conv_w_d,
  input  logic                         clear_start,
  output logic                         clear_busy,
  output logic                         clear_done,
  output logic                         oor_err,
  output clr_st_t                      clear_state
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_st_t               state, state_nxt;
  logic [AW-1:0]         clr_ptr;
  logic                  clr_we;
  logic                  r_in_range, w_in_range;
  logic                  rd_ok, wr_ok, collide;
  logic                  ram_we, ram_re;
  logic [AW-1:0]         ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_q;
  rd_src_t               rd_src;
  logic [DATA_WIDTH-1:0] byp_q;

  // Client handshake: no back-pressure; a read or write is taken on every edge its enable is high.
  assign r_in_range = (conv_r_addr <= LAST);
  assign w_in_range = (conv_w_addr <= LAST);
  assign rd_ok      = conv_r_en && !clear_busy && r_in_range;
  assign wr_ok      = conv_w_en && conv_w_we && !clear_busy && w_in_range;
  assign collide    = rd_ok && wr_ok && (conv_r_addr == conv_w_addr);

  assign ram_we    = clr_we || wr_ok;
  assign ram_waddr = clr_we ? clr_ptr : conv_w_addr;
  assign ram_wdata = clr_we ? '0 : conv_w_d;
  assign ram_re    = rd_ok && !collide;

  fmap_ram_core #(
    .W     (DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (conv_r_addr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_start) state_nxt = CLEAR;
      CLEAR:   if (clr_ptr == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clear_busy = 1'b0;
    clear_done = 1'b0;
    clr_we     = 1'b0;
    case (state)
      CLEAR: begin
        clear_busy = 1'b1;
        clr_we     = 1'b1;
      end
      DONE: begin
        clear_busy = 1'b1;
        clear_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign clear_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              clr_ptr <= '0;
    else if (state == IDLE && clear_start)  clr_ptr <= '0;
    else if (state == CLEAR)                clr_ptr <= clr_ptr + AW'(1);
  end

  // Read source is latched alongside the RAM read so conv_r_q holds while conv_r_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_src <= SRC_ZERO;
      byp_q  <= '0;
    end else if (conv_r_en) begin
      if (collide) begin
        rd_src <= SRC_BYP;
        byp_q  <= conv_w_d;
      end else if (rd_ok) begin
        rd_src <= SRC_RAM;
      end else begin
        rd_src <= SRC_ZERO;
      end
    end
  end

  always_comb begin
    case (rd_src)
      SRC_RAM: conv_r_q = ram_q;
      SRC_BYP: conv_r_q = byp_q;
      default: conv_r_q = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oor_err <= 1'b0;
    end else if (state == IDLE && clear_start) begin
      oor_err <= 1'b0;
    end else if (!clear_busy && ((conv_r_en && !r_in_range) || (conv_w_en && !w_in_range))) begin
      oor_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fmap_buffer.sv
// Randomized scoreboard bench for fmap_buffer against a word-array model of the buffer.
module tb_fmap_buffer;
  import cnn_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 6272;
  localparam int AW    = 13;

  logic                 clk;
  logic                 reset;
  logic [AW-1:0]        conv_r_addr;
  logic                 conv_r_en;
  logic signed [DW-1:0] conv_r_q;
  logic [AW-1:0]        conv_w_addr;
  logic                 conv_w_en;
  logic                 conv_w_we;
  logic signed [DW-1:0] conv_w_d;
  logic                 clear_start;
  logic                 clear_busy;
  logic                 clear_done;
  logic                 oor_err;
  clr_st_t              clear_state;

  fmap_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .conv_r_addr (conv_r_addr),
    .conv_r_en   (conv_r_en),
    .conv_r_q    (conv_r_q),
    .conv_w_addr (conv_w_addr),
    .conv_w_en   (conv_w_en),
    .conv_w_we   (conv_w_we),
    .conv_w_d    (conv_w_d),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .oor_err     (oor_err),
    .clear_state (clear_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] mmem   [DEPTH];
  bit            mknown [DEPTH];
  int            clr_left;          // busy cycles remaining, including the current one
  bit            m_oor;
  bit            exp_busy, exp_done, exp_oor;

  logic [DW-1:0] exp_q[$];
  bit            care_q[$];
  int            checks, errors;
  int            busy_cnt, done_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of client stimulus and advance the model across the coming edge.
  task automatic step(input bit re, input logic [AW-1:0] ra, input bit wen, input bit we,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input bit st);
    bit busy, r_ok, w_ok;
    @(negedge clk);
    conv_r_en = re; conv_r_addr = ra;
    conv_w_en = wen; conv_w_we = we; conv_w_addr = wa; conv_w_d = wd;
    clear_start = st;
    busy = (clr_left > 0);
    r_ok = (int'(ra) < DEPTH);
    w_ok = (int'(wa) < DEPTH);
    if (re) begin
      if (busy || !r_ok) begin
        exp_q.push_back('0); care_q.push_back(1'b1);
      end else if (wen && we && w_ok && wa == ra) begin
        exp_q.push_back(wd); care_q.push_back(1'b1);
      end else begin
        exp_q.push_back(mmem[ra]); care_q.push_back(mknown[ra]);
      end
    end
    if (!busy && wen && we && w_ok) begin
      mmem[wa] = wd; mknown[wa] = 1'b1;
    end
    if (busy) begin
      clr_left--;
    end else if (st) begin
      clr_left = DEPTH + 1;
      m_oor = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin mmem[i] = '0; mknown[i] = 1'b1; end
    end else if ((re && !r_ok) || (wen && !w_ok)) begin
      m_oor = 1'b1;
    end
    exp_busy = (clr_left > 0);
    exp_done = (clr_left == 1);
    exp_oor  = m_oor;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic rd(input int a);
    step(1, AW'(a), 0, 0, '0, '0, 0);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    step(0, '0, 1, 1, AW'(a), d, 0);
  endtask

  // Asynchronous reset between edges; an interrupted clear leaves only its zeroed prefix known.
  task automatic do_reset(input int n);
    int written;
    @(negedge clk);
    #1;
    reset = 1'b1;
    conv_r_en = 0; conv_w_en = 0; conv_w_we = 0; clear_start = 0;
    if (clr_left >= 2) begin
      written = DEPTH + 1 - clr_left;
      for (int i = written; i < DEPTH; i++) mknown[i] = 1'b0;
    end
    clr_left = 0; m_oor = 0;
    exp_busy = 0; exp_done = 0; exp_oor = 0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [DW-1:0] cur_exp;
  bit            cur_care;

  always begin
    bit issued;
    @(posedge clk);
    issued = conv_r_en && !reset;
    #1;
    if (reset) begin
      cur_exp = '0; cur_care = 1'b1;
    end else if (issued) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_underflow", 32'd1, 32'd0);
      end else begin
        cur_exp = exp_q.pop_front(); cur_care = care_q.pop_front();
      end
    end
    if (cur_care) chk("conv_r_q", $unsigned(conv_r_q), cur_exp);
    chk("clear_busy", clear_busy, exp_busy);
    chk("clear_done", clear_done, exp_done);
    chk("oor_err", oor_err, exp_oor);
    if (clear_busy === 1'b1) busy_cnt++;
    if (clear_done === 1'b1) done_cnt++;
  end

  initial begin
    #4_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] v;
    int ra, wa;
    bit re, wen, we;
    checks = 0; errors = 0;
    clr_left = 0; m_oor = 0; exp_busy = 0; exp_done = 0; exp_oor = 0;
    cur_exp = '0; cur_care = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin mmem[i] = '0; mknown[i] = 1'b0; end
    reset = 1'b1;
    conv_r_en = 0; conv_r_addr = '0; conv_w_en = 0; conv_w_we = 0;
    conv_w_addr = '0; conv_w_d = '0; clear_start = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // write then read next cycle; same-edge write-first collision
    wr(5, 16'h1234);
    rd(5);
    wr(100, 16'h0001);
    step(1, AW'(100), 1, 1, AW'(100), 16'h7FFF, 0);
    rd(100);
    idle(2);

    // fill with a pattern, zero-fill with an ignored restart and ignored client traffic
    for (int i = 0; i < DEPTH; i++) wr(i, DW'(i ^ 'h5A5));
    rd(7); rd(DEPTH - 1);
    busy_cnt = 0; done_cnt = 0;
    step(0, '0, 0, 0, '0, '0, 1);
    for (int k = 0; exp_busy; k++) begin
      step($urandom_range(0, 1), AW'($urandom_range(0, DEPTH - 1)), 1, 1,
           AW'($urandom_range(0, DEPTH - 1)), DW'($urandom), (k == 100));
    end
    idle(1);
    chk("busy_cycles", busy_cnt, DEPTH + 1);
    chk("done_pulses", done_cnt, 1);
    for (int i = 0; i < DEPTH; i++) rd(i);

    // random mixed traffic with collisions and occasional out-of-range addresses
    for (int k = 0; k < 3000; k++) begin
      re  = $urandom_range(0, 1);
      wen = $urandom_range(0, 1);
      we  = ($urandom_range(0, 3) != 0);
      ra  = ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, 8191) : $urandom_range(0, DEPTH - 1);
      wa  = ($urandom_range(0, 5) == 0) ? ra :
            (($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, 8191) : $urandom_range(0, DEPTH - 1));
      if (wen && !we && wa >= DEPTH) wa = ra % DEPTH;
      step(re, AW'(ra), wen, we, AW'(wa), DW'($urandom), 0);
    end

    // out-of-range access and aliases, then clear with a second pulse and a mid-clear reset
    do_reset(2);
    idle(1);
    rd(DEPTH);
    wr(8000, 16'hBEEF);
    rd(8000 - DEPTH); rd(8000 & 'hFFF); rd(DEPTH & 'hFFF); rd(0);
    idle(1);
    step(0, '0, 0, 0, '0, '0, 1);
    idle(9);
    step(0, '0, 0, 0, '0, '0, 1);
    idle(9);
    do_reset(2);
    for (int i = 0; i < 19; i++) rd(i);
    idle(2);

    // fill random, then read / write-back max(v,0) two cycles later across the whole buffer
    for (int i = 0; i < DEPTH; i++) wr(i, DW'($urandom));
    for (int k = 0; k < DEPTH + 2; k++) begin
      v = '0;
      if (k >= 2) v = ($signed(mmem[k - 2]) < 0) ? '0 : mmem[k - 2];
      step(k < DEPTH, AW'(k < DEPTH ? k : 0), k >= 2, k >= 2, AW'(k >= 2 ? k - 2 : 0), v, 0);
    end
    for (int i = 0; i < DEPTH; i++) rd(i);
    idle(3);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
